int65_ctrl: RTL and testbench
=============================

# int65_ctrl

Parametrised interrupt front end for the 65xx core: replaces the core's single IRQ/NMI latches with an N-channel maskable IRQ controller plus NMI edge detection and reset sequencing. Samples sources only at the CPU's interrupt-sampling points, freezes one winning source, and presents its vector address and BRK-flag value until the CPU acknowledges the vector fetch. Sits between the peripheral interrupt lines and the CPU sequencer; the CPU supplies sample/ack strobes and the I flag.

## Interface
- NUM_IRQ, 4, number of IRQ channels, legal range 1..8
- VEC_BASE, 16'hFFE0, base of the per-channel vector table (vectored mode only)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- irq_i  in  NUM_IRQ  level-sensitive IRQ requests, active-high
- nmi_i  in  1  NMI request, rising-edge sensitive
- i_flag_i  in  1  CPU P.I flag; 1 masks all IRQ channels
- sample_i  in  1  CPU sampling point (T0, or T2 of a branch)
- ack_i  in  1  CPU vector-fetch start / I-flag set; consumes the frozen source
- mask_we_i  in  1  write strobe for channel-enable register
- mask_wdata_i  in  NUM_IRQ  new channel-enable value
- mask_o  out  NUM_IRQ  current channel-enable register (1 = enabled)
- int_pending_o  out  1  interrupt to be taken at next T1 (forces IR = 00)
- int_nmi_o  out  1  frozen source is NMI
- brk_o  out  1  B bit value to push: 0 while a hardware source is frozen, else 1
- vec_addr_o  out  16  even (low-byte) vector address of frozen source; high byte at +1
- irq_ack_o  out  NUM_IRQ  one-cycle pulse to the acknowledged IRQ channel

## Operation
- irq_i registered once (irq_q); nmi_i registered (nmi_q); NMI edge = nmi_i & ~nmi_q sets nmi_pend.
- Reset sets reset_pend=1, mask=all ones, nmi_pend=0, irq_ack_o=0, int_pending_o=1, frozen source=RESET.
- States: IDLE, FROZEN. IDLE + sample_i + candidate exists -> FROZEN, int_pending_o=1 next cycle.
- Candidate priority: RESET (reset_pend) > NMI (nmi_pend) > lowest-index k with irq_q[k] & mask[k] & ~i_flag_i.
- FROZEN: source, vector, int_nmi_o held; later samples ignored; new NMI edges still set nmi_pend.
- FROZEN + ack_i -> IDLE: int_pending_o=0; clear reset_pend or nmi_pend for the frozen source; if IRQ k, irq_ack_o[k]=1 for one cycle.
- NMI edge in same cycle as NMI ack: set wins, nmi_pend stays 1.
- ack_i in IDLE: ignored, no pulse.
- Vectors: RESET FFFC, NMI FFFA, IRQ per Configuration.
- brk_o=0 whenever FROZEN, 1 in IDLE.
- mask_we_i takes effect next cycle; does not alter an already frozen IRQ.

## Timing
- irq_i to eligible: 1 cycle (irq_q); sample_i in cycle n uses irq_q, pending visible cycle n+1.
- nmi_i rising at n -> nmi_pend at n+1 -> eligible at first sample_i from n+1.
- ack_i at n -> int_pending_o low and irq_ack_o pulse at n+1; new source can freeze on sample_i at n+1 or later.
- reset mid-operation: all state returns to reset values next cycle, any frozen IRQ dropped without ack pulse.

## Configuration
- INT65_VECTORED_EN defined: IRQ k vector = VEC_BASE + 2*k (FFE0..FFEE for 8 channels).
- Undefined: all IRQ channels use FFFE (classic 6502); priority, masking and irq_ack_o unchanged.

## Structure
- Package int65_pkg: source enum (SRC_RESET, SRC_NMI, SRC_IRQ), VEC_RESET=16'hFFFC, VEC_NMI=16'hFFFA, VEC_IRQ=16'hFFFE.
- Sub-module int65_prio_enc: parametrised lowest-index-first encoder (valid + index) over NUM_IRQ bits.

## Test plan
- Reset released, sample_i, ack_i -> vec_addr_o=FFFC, brk_o=0 while frozen, reset_pend cleared, no irq_ack_o pulse.
- irq_i=4'b0110, i_flag_i=0, sample_i -> channel 1 frozen; vectored vec_addr_o=FFE2 (else FFFE); ack_i -> irq_ack_o=4'b0010.
- NMI edge while IRQ 2 frozen -> vector stays IRQ 2; after ack, next sample freezes NMI, vec_addr_o=FFFA, int_nmi_o=1.
- i_flag_i=1 or mask=4'b0000 with irq_i=4'b1111 -> sample_i never sets int_pending_o; NMI still taken.
- nmi_i held high across ack -> single NMI taken; second rising edge coincident with ack -> nmi_pend remains 1, second NMI taken.
- reset asserted while FROZEN on IRQ 3 -> next cycle source=RESET, mask=4'b1111, no irq_ack_o pulse.

Source files
------------

// File: rtl/int65_pkg.sv
// int65_pkg: shared types and fixed vector addresses for the 65xx interrupt front end.
package int65_pkg;
  typedef enum logic [1:0] {SRC_RESET, SRC_NMI, SRC_IRQ} src_e;
  typedef enum logic {ST_IDLE, ST_FROZEN} state_e;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;
endpackage

// File: rtl/int65_prio_enc.sv
// int65_prio_enc: lowest-index-first priority encoder producing valid + index.
module int65_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i]) idx_o = IW'(i);
    valid_o = |req_i;
  end
endmodule

// File: rtl/int65_ctrl.sv
// int65_ctrl: N-channel maskable IRQ, NMI edge and reset sequencing for the 65xx core.
// Define INT65_VECTORED_EN to give each IRQ channel its own vector at VEC_BASE + 2*k.
module int65_ctrl
  import int65_pkg::*;
#(
  parameter int          NUM_IRQ  = 4,
  parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               nmi_i,
  input  logic               i_flag_i,
  input  logic               sample_i,
  input  logic               ack_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] mask_wdata_i,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic               int_pending_o,
  output logic               int_nmi_o,
  output logic               brk_o,
  output logic [15:0]        vec_addr_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
`ifdef INT65_VECTORED_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif
  state_e state_q, state_d;
  src_e src_q, src_d;
  logic [IW-1:0] idx_q, idx_d, enc_idx;
  logic reset_pend_q, reset_pend_d, nmi_pend_q, nmi_pend_d, nmi_q, nmi_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d, mask_q, mask_d, irq_ack_q, irq_ack_d;
  logic enc_valid, ack_fire;
  logic [15:0] irq_vec;
  int65_prio_enc #(.N(NUM_IRQ), .IW(IW)) u_enc (
    .req_i  (irq_q & mask_q & {NUM_IRQ{~i_flag_i}}),
    .valid_o(enc_valid),
    .idx_o  (enc_idx)
  );
  always_comb begin
    irq_d = irq_i;
    nmi_d = nmi_i;
    state_d = state_q;
    src_d = src_q;
    idx_d = idx_q;
    irq_ack_d = '0;
    mask_d = mask_we_i ? mask_wdata_i : mask_q;
    ack_fire = (state_q == ST_FROZEN) && ack_i;
    reset_pend_d = reset_pend_q & ~(ack_fire && src_q == SRC_RESET);
    // A fresh NMI edge in the ack cycle must survive the clear.
    nmi_pend_d = (nmi_i & ~nmi_q) | (nmi_pend_q & ~(ack_fire && src_q == SRC_NMI));
    if (ack_fire) begin
      state_d = ST_IDLE;
      irq_ack_d = (src_q == SRC_IRQ) ? NUM_IRQ'(1) << idx_q : '0;
    end else if (state_q == ST_IDLE && sample_i && (reset_pend_q | nmi_pend_q | enc_valid)) begin
      state_d = ST_FROZEN;
      src_d = reset_pend_q ? SRC_RESET : nmi_pend_q ? SRC_NMI : SRC_IRQ;
      idx_d = enc_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FROZEN;
      src_q <= SRC_RESET;
      idx_q <= '0;
      reset_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_q <= 1'b0;
      irq_q <= '0;
      mask_q <= '1;
      irq_ack_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      idx_q <= idx_d;
      reset_pend_q <= reset_pend_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_q <= nmi_d;
      irq_q <= irq_d;
      mask_q <= mask_d;
      irq_ack_q <= irq_ack_d;
    end
  end
  always_comb begin
    irq_vec = VECTORED ? VEC_BASE + 16'({idx_q, 1'b0}) : VEC_IRQ;
    vec_addr_o = (src_q == SRC_RESET) ? VEC_RESET : (src_q == SRC_NMI) ? VEC_NMI : irq_vec;
  end
  assign int_pending_o = state_q == ST_FROZEN;
  assign brk_o = state_q != ST_FROZEN;
  assign int_nmi_o = (state_q == ST_FROZEN) && src_q == SRC_NMI;
  assign mask_o = mask_q;
  assign irq_ack_o = irq_ack_q;
endmodule

// File: tb/tb_int65_ctrl.sv
// tb_int65_ctrl: directed self-checking bench for int65_ctrl (NUM_IRQ = 4).
module tb_int65_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] irq_i = '0, mask_wdata_i = '0;
  logic nmi_i = 1'b0, i_flag_i = 1'b0, sample_i = 1'b0, ack_i = 1'b0, mask_we_i = 1'b0;
  logic [3:0] mask_o, irq_ack_o;
  logic int_pending_o, int_nmi_o, brk_o;
  logic [15:0] vec_addr_o;
  int tests = 0, fails = 0;
  int65_ctrl #(.NUM_IRQ(4), .VEC_BASE(16'hFFE0)) dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .nmi_i(nmi_i), .i_flag_i(i_flag_i),
    .sample_i(sample_i), .ack_i(ack_i), .mask_we_i(mask_we_i), .mask_wdata_i(mask_wdata_i),
    .mask_o(mask_o), .int_pending_o(int_pending_o), .int_nmi_o(int_nmi_o), .brk_o(brk_o),
    .vec_addr_o(vec_addr_o), .irq_ack_o(irq_ack_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] irqv(input int k);
`ifdef INT65_VECTORED_EN
    return 16'hFFE0 + 16'(2 * k);
`else
    return 16'hFFFE + 16'(0 * k);
`endif
  endfunction
  initial begin
    tick(); tick();
    chk("rst_pending", 16'(int_pending_o), 16'h1);
    chk("rst_vec", vec_addr_o, 16'hFFFC);
    chk("rst_brk", 16'(brk_o), 16'h0);
    chk("rst_mask", 16'(mask_o), 16'hF);
    chk("rst_ack", 16'(irq_ack_o), 16'h0);
    reset = 0; sample_i = 1; tick();
    chk("rst_sample_ignored_vec", vec_addr_o, 16'hFFFC);
    sample_i = 0; ack_i = 1; tick();
    chk("rst_ack_pending", 16'(int_pending_o), 16'h0);
    chk("rst_ack_brk", 16'(brk_o), 16'h1);
    chk("rst_ack_nopulse", 16'(irq_ack_o), 16'h0);
    ack_i = 0; sample_i = 1; tick();
    chk("reset_pend_cleared", 16'(int_pending_o), 16'h0);
    sample_i = 0; irq_i = 4'b0110; tick();
    sample_i = 1; tick();
    chk("irq1_pending", 16'(int_pending_o), 16'h1);
    chk("irq1_vec", vec_addr_o, irqv(1));
    chk("irq1_brk", 16'(brk_o), 16'h0);
    chk("irq1_nmi", 16'(int_nmi_o), 16'h0);
    sample_i = 0; ack_i = 1; tick();
    chk("irq1_ack_pulse", 16'(irq_ack_o), 16'h2);
    chk("irq1_ack_pending", 16'(int_pending_o), 16'h0);
    tick();
    chk("irq1_ack_one_cycle", 16'(irq_ack_o), 16'h0);
    ack_i = 0; irq_i = 4'b0100; tick();
    sample_i = 1; tick();
    chk("irq2_vec", vec_addr_o, irqv(2));
    sample_i = 0; nmi_i = 1; tick();
    sample_i = 1; tick();
    chk("irq2_held_vec", vec_addr_o, irqv(2));
    chk("irq2_held_nmi", 16'(int_nmi_o), 16'h0);
    sample_i = 0; ack_i = 1; tick();
    chk("irq2_ack_pulse", 16'(irq_ack_o), 16'h4);
    ack_i = 0; sample_i = 1; tick();
    chk("nmi_taken_pending", 16'(int_pending_o), 16'h1);
    chk("nmi_taken_flag", 16'(int_nmi_o), 16'h1);
    chk("nmi_vec", vec_addr_o, 16'hFFFA);
    sample_i = 0; ack_i = 1; tick();
    chk("nmi_ack_pending", 16'(int_pending_o), 16'h0);
    chk("nmi_ack_nopulse", 16'(irq_ack_o), 16'h0);
    ack_i = 0; irq_i = 4'b0000; tick(); tick();
    sample_i = 1; tick();
    chk("nmi_held_single", 16'(int_pending_o), 16'h0);
    sample_i = 0; ack_i = 1; tick();
    chk("idle_ack_nopulse", 16'(irq_ack_o), 16'h0);
    ack_i = 0; i_flag_i = 1; irq_i = 4'b1111; tick();
    sample_i = 1; tick();
    chk("iflag_masks", 16'(int_pending_o), 16'h0);
    sample_i = 0; i_flag_i = 0; mask_we_i = 1; mask_wdata_i = 4'b0000; tick();
    chk("mask_write", 16'(mask_o), 16'h0);
    mask_we_i = 0; sample_i = 1; tick();
    chk("mask_zero_blocks", 16'(int_pending_o), 16'h0);
    sample_i = 0; nmi_i = 0; tick();
    nmi_i = 1; tick();
    sample_i = 1; tick();
    chk("masked_nmi_taken", 16'(int_nmi_o), 16'h1);
    sample_i = 0; nmi_i = 0; tick();
    nmi_i = 1; ack_i = 1; tick();
    chk("coinc_ack_pending", 16'(int_pending_o), 16'h0);
    ack_i = 0; sample_i = 1; tick();
    chk("coinc_second_nmi", 16'(int_nmi_o), 16'h1);
    chk("coinc_second_vec", vec_addr_o, 16'hFFFA);
    sample_i = 0; ack_i = 1; tick();
    ack_i = 0; sample_i = 1; tick();
    chk("coinc_no_third", 16'(int_pending_o), 16'h0);
    sample_i = 0; mask_we_i = 1; mask_wdata_i = 4'b1000; irq_i = 4'b1000; tick();
    chk("mask_ch3", 16'(mask_o), 16'h8);
    mask_we_i = 0; sample_i = 1; tick();
    chk("irq3_vec", vec_addr_o, irqv(3));
    chk("irq3_pending", 16'(int_pending_o), 16'h1);
    sample_i = 0; reset = 1; ack_i = 1; tick();
    chk("midrst_vec", vec_addr_o, 16'hFFFC);
    chk("midrst_pending", 16'(int_pending_o), 16'h1);
    chk("midrst_mask", 16'(mask_o), 16'hF);
    chk("midrst_nopulse", 16'(irq_ack_o), 16'h0);
    reset = 0; ack_i = 0; tick();
    chk("midrst_after_nopulse", 16'(irq_ack_o), 16'h0);
    chk("midrst_after_vec", vec_addr_o, 16'hFFFC);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
